// File: rtl/vga_text_overlay_if.sv
// Signal bundle connecting the text overlay to its glyph ROM, text source and VGA connector.
// The overlay drives through "master"; the ROM/connector side uses "slave".
interface vga_text_overlay_if #(
  parameter int N_CHARS = 6
);
  logic [6*N_CHARS-1:0] vc_data;
  logic [11:0]          fg_color;
  logic [11:0]          bg_color;
  logic [5:0]           glyph_code;
  logic [2:0]           glyph_col;
  logic [7:0]           glyph_bits;
  logic [11:0]          rgb;
  logic                 hs;
  logic                 vs;
  logic                 de;
  logic                 frame_start;

  modport master (
    input  vc_data, fg_color, bg_color, glyph_bits,
    output glyph_code, glyph_col, rgb, hs, vs, de, frame_start
  );

  modport slave (
    output vc_data, fg_color, bg_color, glyph_bits,
    input  glyph_code, glyph_col, rgb, hs, vs, de, frame_start
  );
endinterface

// File: rtl/vga_text_overlay.sv
// VGA timing generator that draws a row of ROM glyphs at a fixed origin and power-of-two scale.
// Text is shadowed once per frame; all video outputs are aligned two pixel ticks after the counters.
module vga_text_overlay #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 29,
  parameter int N_CHARS    = 6,
  parameter int GLYPH_COLS = 7,
  parameter int SCALE_LOG2 = 0,
  parameter int ORIGIN_X   = 285,
  parameter int ORIGIN_Y   = 236
) (
  input  logic               clk,
  input  logic               rst,
  vga_text_overlay_if.master bus
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int CW      = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int BW      = (N_CHARS * GLYPH_COLS) << SCALE_LOG2;
  localparam int BH      = 8 << SCALE_LOG2;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;

  // Box edges are clamped to the active area so a clipped box never wraps.
  localparam int HBX0 = (ORIGIN_X < H_ACTIVE)      ? HA0 + ORIGIN_X      : HA0 + H_ACTIVE;
  localparam int HBX1 = (ORIGIN_X + BW < H_ACTIVE) ? HA0 + ORIGIN_X + BW : HA0 + H_ACTIVE;
  localparam int VBX0 = (ORIGIN_Y < V_ACTIVE)      ? VA0 + ORIGIN_Y      : VA0 + V_ACTIVE;
  localparam int VBX1 = (ORIGIN_Y + BH < V_ACTIVE) ? VA0 + ORIGIN_Y + BH : VA0 + V_ACTIVE;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
  localparam logic [HW-1:0] HA0_C    = HW'(HA0);
  localparam logic [HW-1:0] HA1_C    = HW'(HA0 + H_ACTIVE);
  localparam logic [HW-1:0] HBX0_C   = HW'(HBX0);
  localparam logic [HW-1:0] HBX1_C   = HW'(HBX1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
  localparam logic [VW-1:0] VA0_C    = VW'(VA0);
  localparam logic [VW-1:0] VA1_C    = VW'(VA0 + V_ACTIVE);
  localparam logic [VW-1:0] VBX0_C   = VW'(VBX0);
  localparam logic [VW-1:0] VBX1_C   = VW'(VBX1);
  localparam logic [2:0]    SUB_LAST = 3'((1 << SCALE_LOG2) - 1);
  localparam logic [2:0]    COL_LAST = 3'(GLYPH_COLS - 1);

  logic [DW-1:0]        div_q;
  logic                 tick_en;
  logic [HW-1:0]        hcount_q;
  logic [VW-1:0]        vcount_q;
  logic                 h_wrap;
  logic                 v_wrap;
  logic [6*N_CHARS-1:0] shadow_q;
  logic                 frame_start_q;
  logic [5:0]           codes [N_CHARS];

  logic                 de_raw;
  logic                 in_box_x;
  logic                 inside_raw;
  logic [VW-1:0]        v_off;
  logic [2:0]           row_raw;

  logic [2:0]           sub_q, sub_d;
  logic [2:0]           col_q, col_d;
  logic [CW-1:0]        chr_q, chr_d;

  logic [5:0]           glyph_code_q;
  logic [2:0]           glyph_col_q;
  logic [2:0]           row_q;
  logic                 inside_q;
  logic                 s1_de_q;
  logic                 s1_hs_q;
  logic                 s1_vs_q;

  logic [11:0]          rgb_q, rgb_d;
  logic                 de_q;
  logic                 hs_q;
  logic                 vs_q;

  assign tick_en = (div_q == DIV_LAST);
  assign h_wrap  = (hcount_q == H_LAST);
  assign v_wrap  = (vcount_q == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= tick_en ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (tick_en) begin
      hcount_q <= h_wrap ? '0 : hcount_q + HW'(1);
      if (h_wrap) begin
        vcount_q <= v_wrap ? '0 : vcount_q + VW'(1);
      end
    end
  end

  // Text is taken only at the frame wrap so a frame is never drawn from two strings.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick_en && h_wrap && v_wrap;
      if (tick_en && h_wrap && v_wrap) begin
        shadow_q <= bus.vc_data;
      end
    end
  end

  for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_code
    assign codes[gi] = shadow_q[6*(N_CHARS-1-gi) +: 6];
  end

  assign de_raw     = (hcount_q >= HA0_C) && (hcount_q < HA1_C) &&
                      (vcount_q >= VA0_C) && (vcount_q < VA1_C);
  assign in_box_x   = (hcount_q >= HBX0_C) && (hcount_q < HBX1_C);
  assign inside_raw = in_box_x && (vcount_q >= VBX0_C) && (vcount_q < VBX1_C);
  assign v_off      = vcount_q - VBX0_C;
  assign row_raw    = 3'(v_off >> SCALE_LOG2);

  // Sub-pixel/column/char counters replace the divide by GLYPH_COLS; they hold zero outside the box.
  always_comb begin
    sub_d = '0;
    col_d = '0;
    chr_d = '0;
    if (in_box_x) begin
      sub_d = sub_q + 3'd1;
      col_d = col_q;
      chr_d = chr_q;
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        col_d = col_q + 3'd1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          chr_d = chr_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_q <= '0;
      col_q <= '0;
      chr_q <= '0;
    end else if (tick_en) begin
      sub_q <= sub_d;
      col_q <= col_d;
      chr_q <= chr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glyph_code_q <= '0;
      glyph_col_q  <= '0;
      row_q        <= '0;
      inside_q     <= 1'b0;
      s1_de_q      <= 1'b0;
      s1_hs_q      <= 1'b1;
      s1_vs_q      <= 1'b1;
    end else if (tick_en) begin
      if (inside_raw) begin
        glyph_code_q <= codes[chr_q];
        glyph_col_q  <= col_q;
      end
      row_q    <= row_raw;
      inside_q <= inside_raw;
      s1_de_q  <= de_raw;
      s1_hs_q  <= (hcount_q >= H_SYNC_C);
      s1_vs_q  <= (vcount_q >= V_SYNC_C);
    end
  end

  always_comb begin
    rgb_d = '0;
    if (s1_de_q && inside_q) begin
      rgb_d = bus.glyph_bits[row_q] ? bus.fg_color : bus.bg_color;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (tick_en) begin
      rgb_q <= rgb_d;
      de_q  <= s1_de_q;
      hs_q  <= s1_hs_q;
      vs_q  <= s1_vs_q;
    end
  end

  assign bus.glyph_code  = glyph_code_q;
  assign bus.glyph_col   = glyph_col_q;
  assign bus.rgb         = rgb_q;
  assign bus.de          = de_q;
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_text_overlay.sv
// Two overlays (scale 1x unclipped-x/clipped-y, scale 2x clipped-x) on a reduced raster,
// compared every clock against a pixel-by-pixel reference of the display rules.
module tb_vga_text_overlay;
  localparam int DIV = 3;
  localparam int HA = 64, HF = 5, HS = 6, HB = 5;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int F  = HT * VT;
  localparam int NC = 6, GC = 7;
  localparam int S0 = 0, OX0 = 10, OY0 = 18;
  localparam int S1 = 1, OX1 = 4,  OY1 = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] vc_data;
  logic [11:0] fg, bg;
  logic [7:0]  rom_tbl [64][8];
  logic [35:0] frame_text [16];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          e_cnt    = 0;
  logic [11:0] exp_rgb [2];
  logic        exp_hs [2];
  logic        exp_vs [2];
  logic        exp_de [2];
  logic        exp_fs;

  vga_text_overlay_if #(.N_CHARS(NC)) if0 ();
  vga_text_overlay_if #(.N_CHARS(NC)) if1 ();

  vga_text_overlay #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .N_CHARS(NC), .GLYPH_COLS(GC),
    .SCALE_LOG2(S0), .ORIGIN_X(OX0), .ORIGIN_Y(OY0)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));

  vga_text_overlay #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .N_CHARS(NC), .GLYPH_COLS(GC),
    .SCALE_LOG2(S1), .ORIGIN_X(OX1), .ORIGIN_Y(OY1)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  assign if0.vc_data  = vc_data;
  assign if1.vc_data  = vc_data;
  assign if0.fg_color = fg;
  assign if1.fg_color = fg;
  assign if0.bg_color = bg;
  assign if1.bg_color = bg;

  // Glyph ROMs with one clock of read latency (well inside one pixel tick).
  always @(posedge clk) begin
    if0.glyph_bits <= rom_tbl[if0.glyph_code][if0.glyph_col];
    if1.glyph_bits <= rom_tbl[if1.glyph_code][if1.glyph_col];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", tag, e_cnt, got, want);
    end
  endtask

  // What pixel number p of the raster should look like for one overlay instance.
  function automatic void ref_pixel(input int p, input int s, input int ox, input int oy,
                                    input logic [35:0] txt, input logic [11:0] fgc,
                                    input logic [11:0] bgc, output logic [11:0] rgb,
                                    output logic hs, output logic vs, output logic de);
    int h, v, x, y, u, ci, col, row;
    logic [5:0] code;
    logic [7:0] bits;
    h   = p % HT;
    v   = (p / HT) % VT;
    x   = h - (HS + HB);
    y   = v - (VS + VB);
    hs  = (h >= HS);
    vs  = (v >= VS);
    de  = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    rgb = 12'h000;
    if (de && x >= ox && x < ox + ((NC * GC) << s) && y >= oy && y < oy + (8 << s)) begin
      u    = (x - ox) >> s;
      ci   = u / GC;
      col  = u % GC;
      row  = (y - oy) >> s;
      code = txt[6*(NC-1-ci) +: 6];
      bits = rom_tbl[code][3'(col)];
      rgb  = bits[3'(row)] ? fgc : bgc;
    end
  endfunction

  task automatic reset_model();
    e_cnt         = 0;
    frame_text[0] = '0;
    exp_fs        = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_rgb[i] = 12'h000;
      exp_hs[i]  = 1'b1;
      exp_vs[i]  = 1'b1;
      exp_de[i]  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("u0.rgb", 32'(if0.rgb), 32'(exp_rgb[0]));
    check_eq("u0.hs",  32'(if0.hs),  32'(exp_hs[0]));
    check_eq("u0.vs",  32'(if0.vs),  32'(exp_vs[0]));
    check_eq("u0.de",  32'(if0.de),  32'(exp_de[0]));
    check_eq("u0.frame_start", 32'(if0.frame_start), 32'(exp_fs));
    check_eq("u1.rgb", 32'(if1.rgb), 32'(exp_rgb[1]));
    check_eq("u1.hs",  32'(if1.hs),  32'(exp_hs[1]));
    check_eq("u1.vs",  32'(if1.vs),  32'(exp_vs[1]));
    check_eq("u1.de",  32'(if1.de),  32'(exp_de[1]));
    check_eq("u1.frame_start", 32'(if1.frame_start), 32'(exp_fs));
  endtask

  // One clock: advance the reference, compare, then maybe perturb the inputs.
  task automatic step();
    int n, p;
    @(posedge clk);
    #1;
    e_cnt++;
    exp_fs = 1'b0;
    if (e_cnt % DIV == 0) begin
      n = e_cnt / DIV;
      if (n % F == 0) begin
        frame_text[4'(n / F)] = vc_data;
        exp_fs = 1'b1;
      end
      if (n >= 2) begin
        p = n - 2;
        ref_pixel(p, S0, OX0, OY0, frame_text[4'(p / F)], fg, bg,
                  exp_rgb[0], exp_hs[0], exp_vs[0], exp_de[0]);
        ref_pixel(p, S1, OX1, OY1, frame_text[4'(p / F)], fg, bg,
                  exp_rgb[1], exp_hs[1], exp_vs[1], exp_de[1]);
      end
    end
    check_outputs();
    if (e_cnt % 1013 == 0) vc_data = 36'({$urandom(), $urandom()});
    if (e_cnt % 2203 == 0) begin
      fg = 12'($urandom());
      bg = 12'($urandom());
    end
  endtask

  initial begin
    for (int c = 0; c < 64; c++)
      for (int k = 0; k < 8; k++)
        rom_tbl[c][k] = (c == 3) ? 8'hFF : ((c < 8) ? 8'h00 : 8'($urandom()));
    vc_data = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
    fg = 12'hFFF;
    bg = 12'h00F;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_model();
    check_outputs();
    check_eq("rst.glyph_code", 32'(if0.glyph_code), 32'd0);
    check_eq("rst.glyph_col",  32'(if1.glyph_col),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("reset released, running %0d clocks", 2 * F * DIV + 500);

    for (int i = 0; i < 2 * F * DIV + 500; i++) step();
    for (int c = 8; c < 64; c++)
      for (int k = 0; k < 8; k++) rom_tbl[c][k] = 8'($urandom());

    // Mid-line asynchronous reset: outputs must drop at once, then the raster restarts.
    #2 rst = 1'b0;
    #1;
    reset_model();
    check_outputs();
    $display("mid-line reset applied at %0t", $time);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    vc_data = 36'({$urandom(), $urandom()});
    $display("reset released, running %0d clocks", 3 * F * DIV + 100);
    for (int i = 0; i < 3 * F * DIV + 100; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_text_overlay.md
Name: vga_text_overlay

Overview:
- Parametrised successor to the fixed six-character VGA text display.
- Generates VGA sync timing from the system clock and draws a row of N_CHARS 6-bit character codes at a configurable origin and power-of-two scale, with fg/bg colours.
- Reads glyph columns from an external 1-tick-latency character ROM.
- Latches text once per frame so the display never tears; drives the board VGA connector.

Parameters:
- CLK_DIV, 4: system clocks per pixel tick (>=2).
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640/16/96/48: horizontal timing in ticks. Line order is sync, back porch, active, front porch.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480/10/2/29: vertical timing in lines, same ordering.
- N_CHARS, 6: characters per row (1..16).
- GLYPH_COLS, 7: columns per glyph. Each column is 8 bits; bit r = row r.
- SCALE_LOG2, 0: pixel replication factor 2^SCALE_LOG2 (0..3).
- ORIGIN_X, 285: box left edge, in active-area pixels.
- ORIGIN_Y, 236: box top edge, in active-area lines.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- vc_data  in  6*N_CHARS  character codes; char 0 in the MSBs (leftmost on screen)
- fg_color  in  12  RGB444 colour for set glyph bits
- bg_color  in  12  RGB444 colour inside the box for clear bits
- glyph_code  out  6  ROM address: character code
- glyph_col  out  3  ROM address: column index
- glyph_bits  in  8  ROM data, valid one pixel tick after the address
- rgb  out  12  pixel colour
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- de  out  1  display enable (active area)
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- Reset (rst low, asynchronous): divider, counters, shadow text, glyph_code, glyph_col, rgb, de and frame_start all go to 0. hs and vs go to 1 (inactive).
- Pixel tick: tick_en is high for one clk every CLK_DIV clks; the first tick occurs CLK_DIV clks after reset release. All registers below update only on tick_en, except frame_start.
- Counters:
  - hcount runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP = 800.
  - vcount increments when hcount wraps; it runs 0..V_TOTAL-1 (521) and then wraps to 0.
  - Raw sync signals are hs_raw = (hcount >= H_SYNC) and vs_raw = (vcount >= V_SYNC).
  - Active pixel x = hcount-(H_SYNC+H_BP) and line y = vcount-(V_SYNC+V_BP), only when in range.
- Shadow text:
  - On the tick where hcount and vcount both wrap to 0, vc_data is copied into shadow and frame_start pulses for that single clk.
  - Changes to vc_data mid-frame are invisible until the next frame.
- Box geometry:
  - Width BW = N_CHARS*GLYPH_COLS<<SCALE_LOG2; height BH = 8<<SCALE_LOG2.
  - A pixel is inside when ORIGIN_X <= x < ORIGIN_X+BW and ORIGIN_Y <= y < ORIGIN_Y+BH.
  - Within the box: u = (x-ORIGIN_X)>>SCALE_LOG2, char index = u / GLYPH_COLS, column = u % GLYPH_COLS, row = (y-ORIGIN_Y)>>SCALE_LOG2.
  - Implement the division with a running column/char counter, not a divider.
- Pipeline (2 ticks):
  - S1 registers glyph_code (shadow code of char index), glyph_col, row, inside, de_raw, hs_raw and vs_raw.
  - S2 registers the outputs:
    - rgb = !de ? 0 : !inside ? 0 : glyph_bits[row] ? fg_color : bg_color.
    - de, hs and vs come from S1.
    - All outputs are therefore mutually aligned, 2 ticks after the counters.
- Outside the box, glyph_code and glyph_col hold their last value; the ROM output is ignored.
- Boundaries:
  - A box clipped by the active-area edge draws only the visible part; there is no wrap.
  - fg_color and bg_color are sampled at S2 with no shadowing.
- Reset mid-frame: immediate return to the reset state, then restart from hcount = 0, vcount = 0.

Test Plan:
- Reset then run 2 lines -> hs low for exactly 96 ticks (384 clks) per 800-tick line; vs low for 2 full lines out of 521; no X on any output after reset.
- Count frame_start pulses over 3 frames -> exactly one pulse every 800*521*4 = 1,667,200 clks.
- vc_data = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6}, ROM model returning 8'hFF for code 3 and 0 otherwise, fg = 12'hFFF, bg = 12'h00F -> pixels x = 299..305 of box lines are FFF; the rest of the box is 00F; outside the box 000.
- SCALE_LOG2 = 1 -> box is 84x16 pixels; each glyph bit occupies a 2x2 block; glyph_col steps every 2 ticks.
- Change vc_data at line 250 -> rgb unchanged until the next frame, then shows the new codes.
- Drop rst low for 3 clks mid-line -> hs = vs = 1 and rgb = de = 0 immediately; after release, timing restarts and the first hs low occurs at tick 0.
